regm_wb_arbiter: RTL and testbench

- Shares the single write port of the register file (regm) between two writeback requesters: source 0 (execute) and source 1 (load/store).
- Each source has a 1-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains the buffers into a registered write port that drives regm write_i/waddr_i/wdata_i directly.
- Writes to x0 are absorbed and never reach regm.

---
 rtl/regm_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regm_wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regm_wb_arbiter.sv
// Round-robin writeback arbiter sharing the regm write port between execute (src0) and load/store (src1).
// Optional combinational write forwarding is enabled by defining REGM_WB_ARBITER_FORWARDING_EN.
module regm_wb_arbiter #(
  parameter int NB_SRC = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              src0_valid_i,
  output logic              src0_ready_o,
  input  logic [ADDR_W-1:0] src0_addr_i,
  input  logic [DATA_W-1:0] src0_data_i,
  input  logic              src1_valid_i,
  output logic              src1_ready_o,
  input  logic [ADDR_W-1:0] src1_addr_i,
  input  logic [DATA_W-1:0] src1_data_i,
  output logic              write_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              busy_o,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic              fwd1_valid_o,
  output logic [DATA_W-1:0] fwd1_data_o,
  output logic              fwd2_valid_o,
  output logic [DATA_W-1:0] fwd2_data_o
);

  logic                      buf0_valid, buf1_valid;
  logic [ADDR_W-1:0]         buf0_addr, buf1_addr;
  logic [DATA_W-1:0]         buf0_data, buf1_data;
  logic [$clog2(NB_SRC)-1:0] ptr;
  logic                      grant0, grant1;
  logic [ADDR_W-1:0]         g_addr;
  logic [DATA_W-1:0]         g_data;

  // Grants come only from registered state, so ready never depends combinationally on inputs.
  always_comb begin
    grant0 = buf0_valid && (!buf1_valid || (ptr == '0));
    grant1 = buf1_valid && (!buf0_valid || (ptr != '0));
    g_addr = buf0_addr;
    g_data = buf0_data;
    if (grant1) begin
      g_addr = buf1_addr;
      g_data = buf1_data;
    end
  end

  assign src0_ready_o = !buf0_valid || grant0;
  assign src1_ready_o = !buf1_valid || grant1;
  assign busy_o       = buf0_valid || buf1_valid || write_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf0_valid <= 1'b0;
      buf0_addr  <= '0;
      buf0_data  <= '0;
      buf1_valid <= 1'b0;
      buf1_addr  <= '0;
      buf1_data  <= '0;
      ptr        <= '0;
      write_o    <= 1'b0;
      waddr_o    <= '0;
      wdata_o    <= '0;
    end else begin
      // A granted buffer may reload in the same edge, giving 1/cycle per source.
      if (src0_valid_i && src0_ready_o) begin
        buf0_valid <= 1'b1;
        buf0_addr  <= src0_addr_i;
        buf0_data  <= src0_data_i;
      end else if (grant0) begin
        buf0_valid <= 1'b0;
      end

      if (src1_valid_i && src1_ready_o) begin
        buf1_valid <= 1'b1;
        buf1_addr  <= src1_addr_i;
        buf1_data  <= src1_data_i;
      end else if (grant1) begin
        buf1_valid <= 1'b0;
      end

      // Only contended grants move the pointer, to the loser.
      if (buf0_valid && buf1_valid) begin
        ptr <= grant0 ? 1'b1 : 1'b0;
      end

      // x0 writes are granted to drain the buffer but never raise write_o.
      if (grant0 || grant1) begin
        write_o <= (g_addr != '0);
        waddr_o <= g_addr;
        wdata_o <= g_data;
      end else begin
        write_o <= 1'b0;
      end
    end
  end

`ifdef REGM_WB_ARBITER_FORWARDING_EN
  // Covers the cycle where regm's read port still returns the pre-write value.
  assign fwd1_valid_o = write_o && (waddr_o == raddr1_i) && (raddr1_i != '0);
  assign fwd1_data_o  = wdata_o;
  assign fwd2_valid_o = write_o && (waddr_o == raddr2_i) && (raddr2_i != '0);
  assign fwd2_data_o  = wdata_o;
`else
  logic unused_raddr;
  assign unused_raddr = ^{raddr1_i, raddr2_i};
  assign fwd1_valid_o = 1'b0;
  assign fwd1_data_o  = '0;
  assign fwd2_valid_o = 1'b0;
  assign fwd2_data_o  = '0;
`endif

endmodule

// File: tb/tb_regm_wb_arbiter.sv
// Scoreboard bench for regm_wb_arbiter: directed writebacks push expected regm writes, a monitor pops them.
module tb_regm_wb_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

`ifdef REGM_WB_ARBITER_FORWARDING_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        src0_valid_i, src1_valid_i;
  logic        src0_ready_o, src1_ready_o;
  logic [4:0]  src0_addr_i, src1_addr_i;
  logic [31:0] src0_data_i, src1_data_i;
  logic        write_o, busy_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic [4:0]  raddr1_i, raddr2_i;
  logic        fwd1_valid_o, fwd2_valid_o;
  logic [31:0] fwd1_data_o, fwd2_data_o;

  int          total = 0;
  int          bad = 0;
  wr_t         exp_q[$];
  logic [31:0] regm_model[32];

  regm_wb_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .src0_valid_i(src0_valid_i), .src0_ready_o(src0_ready_o),
    .src0_addr_i(src0_addr_i), .src0_data_i(src0_data_i),
    .src1_valid_i(src1_valid_i), .src1_ready_o(src1_ready_o),
    .src1_addr_i(src1_addr_i), .src1_data_i(src1_data_i),
    .write_o(write_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .busy_o(busy_o),
    .raddr1_i(raddr1_i), .raddr2_i(raddr2_i),
    .fwd1_valid_o(fwd1_valid_o), .fwd1_data_o(fwd1_data_o),
    .fwd2_valid_o(fwd2_valid_o), .fwd2_data_o(fwd2_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Called at a negedge; ready is stable until the next posedge, so it predicts the handshake.
  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               output logic acc0, output logic acc1);
    src0_valid_i = v0; src0_addr_i = a0; src0_data_i = d0;
    src1_valid_i = v1; src1_addr_i = a1; src1_data_i = d1;
    acc0 = v0 && src0_ready_o;
    acc1 = v1 && src1_ready_o;
    @(posedge clk_i);
    @(negedge clk_i);
    src0_valid_i = 1'b0;
    src1_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    logic x0, x1;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, x0, x1);
  endtask

  always @(negedge clk_i) begin
    wr_t e;
    if (write_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 32'(write_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("waddr", 32'(waddr_o), 32'(e.addr));
        checkOutput("wdata", wdata_o, e.data);
        regm_model[waddr_o] = wdata_o;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic a0, a1;
    int   i0, i1;
    rst_i = 1'b1;
    src0_valid_i = 1'b0; src0_addr_i = '0; src0_data_i = '0;
    src1_valid_i = 1'b0; src1_addr_i = '0; src1_data_i = '0;
    raddr1_i = '0; raddr2_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    checkOutput("rst_write", 32'(write_o), 32'd0);
    checkOutput("rst_waddr", 32'(waddr_o), 32'd0);
    checkOutput("rst_wdata", wdata_o, 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_ready0", 32'(src0_ready_o), 32'd1);
    checkOutput("rst_ready1", 32'(src1_ready_o), 32'd1);

    // Single write: 2-cycle latency, one write cycle only.
    exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, a0, a1);
    checkOutput("t1_accept", 32'(a0), 32'd1);
    checkOutput("t1_write_n1", 32'(write_o), 32'd0);
    checkOutput("t1_busy_n1", 32'(busy_o), 32'd1);
    idle(1);
    checkOutput("t1_write_n2", 32'(write_o), 32'd1);
    idle(1);
    checkOutput("t1_write_n3", 32'(write_o), 32'd0);
    checkOutput("t1_busy_n3", 32'(busy_o), 32'd0);

    // Contention: writes alternate r1,r11,r2,r12,... starting with src0.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{addr: 5'(i + 1), data: 32'(32'h100 + i)});
      exp_q.push_back('{addr: 5'(i + 11), data: 32'(32'h200 + i)});
    end
    i0 = 0; i1 = 0;
    for (int k = 0; k < 30 && (i0 < 4 || i1 < 4); k++) begin
      if (k >= 1 && k <= 6) begin
        checkOutput("t2_ready0", 32'(src0_ready_o), 32'(k % 2 == 1));
        checkOutput("t2_ready1", 32'(src1_ready_o), 32'(k % 2 == 0));
      end
      applyStimulus(i0 < 4, 5'(i0 + 1), 32'(32'h100 + i0),
                    i1 < 4, 5'(i1 + 11), 32'(32'h200 + i1), a0, a1);
      if (a0) i0++;
      if (a1) i1++;
    end
    checkOutput("t2_accepted", 32'(i0 + i1), 32'd8);
    idle(4);
    checkOutput("t2_drained", 32'(exp_q.size()), 32'd0);

    // x0 is accepted and drained without a regm write.
    checkOutput("t3_ready1_pre", 32'(src1_ready_o), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678, a0, a1);
    checkOutput("t3_accept", 32'(a1), 32'd1);
    checkOutput("t3_busy", 32'(busy_o), 32'd1);
    checkOutput("t3_ready1", 32'(src1_ready_o), 32'd1);
    checkOutput("t3_write", 32'(write_o), 32'd0);
    idle(1);
    checkOutput("t3_busy_after", 32'(busy_o), 32'd0);
    checkOutput("t3_write_after", 32'(write_o), 32'd0);

    // Reset with both buffers full discards both pending writes.
    applyStimulus(1'b1, 5'd20, 32'hAAAA, 1'b1, 5'd21, 32'hBBBB, a0, a1);
    checkOutput("t5_accept", 32'({a0, a1}), 32'd3);
    checkOutput("t5_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    checkOutput("t5_write", 32'(write_o), 32'd0);
    checkOutput("t5_busy_after", 32'(busy_o), 32'd0);
    checkOutput("t5_ready0", 32'(src0_ready_o), 32'd1);
    checkOutput("t5_ready1", 32'(src1_ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checkOutput("t5_no_write", 32'(write_o), 32'd0);
    end

    // Same address with pointer back at 0: src0 then src1, final r7 = 2.
    exp_q.push_back('{addr: 5'd7, data: 32'h1});
    exp_q.push_back('{addr: 5'd7, data: 32'h2});
    applyStimulus(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, a0, a1);
    checkOutput("t4_accept", 32'({a0, a1}), 32'd3);
    idle(4);
    checkOutput("t4_r7", regm_model[7], 32'h2);

    // Forwarding on the write_o cycle.
    raddr1_i = 5'd9;
    raddr2_i = 5'd0;
    exp_q.push_back('{addr: 5'd9, data: 32'hCAFE0001});
    applyStimulus(1'b1, 5'd9, 32'hCAFE0001, 1'b0, 5'd0, 32'd0, a0, a1);
    checkOutput("t6_fwd1_early", 32'(fwd1_valid_o), 32'd0);
    idle(1);
    checkOutput("t6_write", 32'(write_o), 32'd1);
    checkOutput("t6_fwd1_valid", 32'(fwd1_valid_o), 32'(FWD_ON));
    checkOutput("t6_fwd1_data", fwd1_data_o, FWD_ON ? 32'hCAFE0001 : 32'd0);
    checkOutput("t6_fwd2_valid", 32'(fwd2_valid_o), 32'd0);
    checkOutput("t6_fwd2_data", fwd2_data_o, FWD_ON ? 32'hCAFE0001 : 32'd0);
    idle(2);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
